// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg : time-field widths, limits and alarm FSM encodings
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  localparam int HOUR_W    = 5;
  localparam int MIN_SEC_W = 6;

  localparam logic [HOUR_W-1:0]    HOUR_MAX    = 5'd23;
  localparam logic [MIN_SEC_W-1:0] MIN_SEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_ARMED  = 3'd2,
    ST_RING   = 3'd3,
    ST_SNOOZE = 3'd4
  } alarm_state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_unit_if.sv
// ---------------------------------------------------------------------------
// alarm_unit_if : user controls, clock time in, alarm status out
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alarm_unit_if;
  import clock_pkg::*;

  logic                 alarm_set;
  logic                 alarm_en;
  logic                 hour_in;
  logic                 min_in;
  logic                 snooze;
  logic                 stop;
  logic [HOUR_W-1:0]    clk_hour;
  logic [MIN_SEC_W-1:0] clk_min;
  logic [MIN_SEC_W-1:0] clk_sec;
  logic [HOUR_W-1:0]    alarm_hour;
  logic [MIN_SEC_W-1:0] alarm_min;
  logic                 ringing;
  logic                 snoozed;
  logic [2:0]           alarm_state;

  modport master (
    output alarm_set, alarm_en, hour_in, min_in, snooze, stop,
           clk_hour, clk_min, clk_sec,
    input  alarm_hour, alarm_min, ringing, snoozed, alarm_state
  );

  modport slave (
    input  alarm_set, alarm_en, hour_in, min_in, snooze, stop,
           clk_hour, clk_min, clk_sec,
    output alarm_hour, alarm_min, ringing, snoozed, alarm_state
  );

endinterface

`default_nettype wire

// File: rtl/alarm_match_detect.sv
// ---------------------------------------------------------------------------
// alarm_match_detect : one-cycle fire pulse on the rising edge of HH:MM:00 match
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_match_detect
  import clock_pkg::*;
(
  input  wire logic                 clk_1Hz,
  input  wire logic                 resetn,
  input  wire logic [HOUR_W-1:0]    clk_hour,
  input  wire logic [MIN_SEC_W-1:0] clk_min,
  input  wire logic [MIN_SEC_W-1:0] clk_sec,
  input  wire logic [HOUR_W-1:0]    alarm_hour,
  input  wire logic [MIN_SEC_W-1:0] alarm_min,
  output logic                      fire
);

  logic match_now;
  logic match_prev;

  // Stored alarm is always in range, so out-of-range clock values cannot match.
  assign match_now = (clk_hour == alarm_hour) && (clk_min == alarm_min) &&
                     (clk_sec == '0);
  assign fire      = match_now && !match_prev;

  // Reset to 1 so a clock already sitting on the alarm time cannot fire at once.
  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) match_prev <= 1'b1;
    else         match_prev <= match_now;
  end

endmodule

`default_nettype wire

// File: rtl/alarm_unit.sv
// ---------------------------------------------------------------------------
// alarm_unit : alarm time storage, ring burst with auto-off and bounded snooze
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_unit
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int DEFAULT_HOUR   = 6,
  parameter int DEFAULT_MIN    = 0
) (
  input  wire logic   clk_1Hz,
  input  wire logic   resetn,
  alarm_unit_if.slave bus
);

  localparam int SNOOZE_CYCLES = SNOOZE_MINUTES * 60;
  localparam int RW = (RING_SECONDS  > 1) ? $clog2(RING_SECONDS)   : 1;
  localparam int SW = (SNOOZE_CYCLES > 1) ? $clog2(SNOOZE_CYCLES)  : 1;
  localparam int TW = (MAX_SNOOZE    > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RW-1:0]        RING_RELOAD   = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0]        SNOOZE_RELOAD = SW'(SNOOZE_CYCLES - 1);
  localparam logic [TW-1:0]        TALLY_MAX     = TW'(MAX_SNOOZE);
  localparam logic [HOUR_W-1:0]    HOUR_RST      = HOUR_W'(DEFAULT_HOUR);
  localparam logic [MIN_SEC_W-1:0] MIN_RST       = MIN_SEC_W'(DEFAULT_MIN);

  alarm_state_t         state;
  logic [HOUR_W-1:0]    alarm_hour;
  logic [MIN_SEC_W-1:0] alarm_min;
  logic                 ringing;
  logic                 snoozed;
  logic [RW-1:0]        ring_cnt;
  logic [SW-1:0]        snooze_cnt;
  logic [TW-1:0]        tally;
  logic                 fire;

  alarm_match_detect u_match (
    .clk_1Hz    (clk_1Hz),
    .resetn     (resetn),
    .clk_hour   (bus.clk_hour),
    .clk_min    (bus.clk_min),
    .clk_sec    (bus.clk_sec),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .fire       (fire)
  );

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      alarm_hour <= HOUR_RST;
      alarm_min  <= MIN_RST;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      tally      <= '0;
    end else if (bus.alarm_set) begin
      // Editing overrides everything and abandons any ring/snooze event.
      state   <= ST_SET;
      ringing <= 1'b0;
      snoozed <= 1'b0;
      tally   <= '0;
      if (state == ST_SET) begin
        if (bus.hour_in)
          alarm_hour <= (alarm_hour == HOUR_MAX) ? '0 : alarm_hour + 5'd1;
        if (bus.min_in)
          alarm_min <= (alarm_min == MIN_SEC_MAX) ? '0 : alarm_min + 6'd1;
      end
    end else begin
      case (state)
        ST_SET:  state <= bus.alarm_en ? ST_ARMED : ST_IDLE;
        ST_IDLE: if (bus.alarm_en) state <= ST_ARMED;
        ST_ARMED: begin
          if (!bus.alarm_en) begin
            state <= ST_IDLE;
          end else if (fire) begin
            state    <= ST_RING;
            ringing  <= 1'b1;
            ring_cnt <= RING_RELOAD;
            tally    <= '0;
          end
        end
        ST_RING: begin
          if (!bus.alarm_en) begin
            state   <= ST_IDLE;
            ringing <= 1'b0;
          end else if (bus.stop) begin
            state   <= ST_ARMED;
            ringing <= 1'b0;
          end else if (bus.snooze && (tally < TALLY_MAX)) begin
            state      <= ST_SNOOZE;
            ringing    <= 1'b0;
            snoozed    <= 1'b1;
            snooze_cnt <= SNOOZE_RELOAD;
            tally      <= tally + 1'b1;
          end else if (ring_cnt == '0) begin
            state   <= ST_ARMED;
            ringing <= 1'b0;
          end else begin
            ring_cnt <= ring_cnt - 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (!bus.alarm_en) begin
            state   <= ST_IDLE;
            snoozed <= 1'b0;
          end else if (bus.stop) begin
            state   <= ST_ARMED;
            snoozed <= 1'b0;
            tally   <= '0;
          end else if (snooze_cnt == '0) begin
            state    <= ST_RING;
            snoozed  <= 1'b0;
            ringing  <= 1'b1;
            ring_cnt <= RING_RELOAD;
          end else begin
            snooze_cnt <= snooze_cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ringing <= 1'b0;
          snoozed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alarm_hour  = alarm_hour;
  assign bus.alarm_min   = alarm_min;
  assign bus.ringing     = ringing;
  assign bus.snoozed     = snoozed;
  assign bus.alarm_state = state;

endmodule

`default_nettype wire

// File: doc/alarm_unit.md
# alarm_unit

- Downstream consumer of the 24-hour clock's `hour_out`/`min_out`/`sec_out`.
- Stores a user-set alarm time and compares it against the running clock every second.
- Drives a ringing indication with auto-off timeout and a bounded snooze facility.
- Outputs feed the display mux (alarm time) and the buzzer/LED driver (`ringing`, `snoozed`).

## Interface
- `RING_SECONDS`, 60: length of one ring burst in clk_1Hz cycles (≥1).
- `SNOOZE_MINUTES`, 5: snooze interval in minutes (≥1).
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event.
- `DEFAULT_HOUR`, 6 / `DEFAULT_MIN`, 0: alarm time loaded at reset.
- `clk_1Hz`  in  1  block clock, all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `alarm_set`  in  1  switch; 1 = edit alarm time.
- `alarm_en`  in  1  switch; 1 = alarm armed.
- `hour_in`, `min_in`  in  1 each  debounced levels; sampled each edge, each high sample = one increment.
- `snooze`, `stop`  in  1 each  debounced levels.
- `clk_hour`  in  5  current hour 0–23 from clock.
- `clk_min`, `clk_sec`  in  6 each  current minute/second 0–59 from clock.
- `alarm_hour`  out  5  stored alarm hour.
- `alarm_min`  out  6  stored alarm minute.
- `ringing`  out  1  alarm sounding.
- `snoozed`  out  1  snooze interval running.
- `alarm_state`  out  3  encoded FSM state for debug/display.

## Operation
- States: IDLE (disarmed), SET, ARMED, RING, SNOOZE.
- Reset values:
  - state = IDLE.
  - `alarm_hour` = DEFAULT_HOUR, `alarm_min` = DEFAULT_MIN.
  - `ringing` = 0, `snoozed` = 0.
  - ring counter, snooze counter, snooze tally = 0.
  - `match_prev` = 1, which suppresses a spurious fire on the first edge.
- `alarm_set`=1 in any state → SET next edge.
  - This has highest priority after reset.
  - Entering SET from RING or SNOOZE cancels the event and clears the tally.
- SET:
  - `hour_in` → `alarm_hour` +1, 23 wraps to 0.
  - `min_in` → `alarm_min` +1, 59 wraps to 0; no carry into hour.
  - Both high in the same cycle → both increment.
  - On `alarm_set`=0 → ARMED if `alarm_en` else IDLE.
- IDLE: `alarm_en`=1 → ARMED.
- ARMED:
  - `alarm_en`=0 → IDLE.
  - Define `match_now` = (`clk_hour`==`alarm_hour` && `clk_min`==`alarm_min` && `clk_sec`==0).
  - Fire on `match_now && !match_prev` (rising edge only). This prevents re-firing while the clock sits frozen at a matching value.
  - On fire: → RING, ring counter = RING_SECONDS−1, tally = 0.
  - `match_prev` is registered every cycle in every state.
- RING (`ringing`=1). Priority order:
  1. `alarm_en`=0 → IDLE.
  2. `stop` → ARMED.
  3. `snooze` with tally < MAX_SNOOZE → SNOOZE; snooze counter = SNOOZE_MINUTES·60−1; tally +1.
  4. Ring counter == 0 → ARMED (auto-off).
  5. Otherwise ring counter −1.
  - `snooze` with tally == MAX_SNOOZE is ignored.
- SNOOZE (`snoozed`=1). Priority order:
  1. `alarm_en`=0 → IDLE.
  2. `stop` → ARMED, tally cleared.
  3. Counter == 0 → RING; ring counter reloaded.
  4. Otherwise counter −1.
- Widths: ring counter = clog2(RING_SECONDS); snooze counter = clog2(SNOOZE_MINUTES·60); tally = clog2(MAX_SNOOZE+1).
- Out-of-range clock inputs (hour > 23, min/sec > 59) simply never match. No error is flagged.

## Timing
- All outputs are registered.
- `ringing` rises on the edge after the clock inputs first show HH:MM:00, i.e. one cycle of latency.
- A ring burst lasts exactly RING_SECONDS cycles when no input intervenes.
- A snooze lasts exactly SNOOZE_MINUTES·60 cycles of `snoozed`=1, then `ringing`=1 on the next cycle.
- `stop`/`snooze`/`alarm_set` take effect on the first edge they are sampled high. Held levels do not re-trigger a snooze: it only applies in RING.
- Async reset mid-RING/SNOOZE: outputs clear immediately; the stored alarm time returns to defaults.

## Structure
- Shared `clock_pkg` holds:
  - state encodings (alarm_state values),
  - HOUR_MAX=23 and MIN_SEC_MAX=59,
  - time-field widths 5/6, shared with the 24-hour clock.
- One sub-module, `alarm_match_detect`:
  - compare plus `match_prev` register,
  - outputs a single-cycle `fire` pulse.
- The FSM and counters stay in `alarm_unit`.

## Test plan
- Reset, `alarm_en`=1, clock sweeps 05:59:58→06:00:01 → `ringing`=1 from the cycle after 06:00:00; it stays high 60 cycles, then returns to 0 with state ARMED.
- SET: hold `hour_in` 20 cycles from 06 → `alarm_hour`=2. Pulse `min_in` at 59 → `alarm_min`=0 and hour unchanged. Both in the same cycle → both increment.
- Ringing, `snooze` at ring cycle 10 → `ringing`=0, `snoozed`=1 for 300 cycles, then ringing resumes. Fourth snooze request is ignored and ringing continues.
- Clock frozen at 06:00:00 (upstream idle) → exactly one fire. After `stop` the block stays ARMED with no re-ring.
- `stop` and `snooze` asserted together while ringing → ARMED. `alarm_en`=0 with `stop` → IDLE.
- `resetn` pulsed low during SNOOZE → `snoozed`=0 and `ringing`=0 immediately; alarm reads 06:00; state IDLE.
